// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALUOp encodings and the control bundle shared by the control pipeline
package ctrl_pkg;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [2:0] ALUOP_RTYPE = 3'b000;
  localparam logic [2:0] ALUOP_IMM   = 3'b001;
  localparam logic [2:0] ALUOP_ADD   = 3'b010;
  localparam logic [2:0] ALUOP_SUB   = 3'b011;
  localparam logic [2:0] ALUOP_PASS  = 3'b100;
  localparam logic [2:0] ALUOP_LINK  = 3'b101;
  typedef struct packed {
    logic       alu_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [2:0] alu_op;
  } ctrl_bundle_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode to control bundle decode with illegal-opcode flag
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]   op,
  output ctrl_bundle_t ctrl,
  output logic         illegal
);
  always_comb begin
    ctrl = '0;
    illegal = 1'b0;
    case (op)
      OPC_R:   ctrl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_RTYPE};
      OPC_I:   ctrl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_IMM};
      OPC_LW:  ctrl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_ADD};
      OPC_SW:  ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_ADD};
      OPC_BEQ: ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_SUB};
      OPC_LUI: ctrl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_PASS};
      OPC_JAL: ctrl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_LINK};
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: main control unit carrying the decoded bundle through ID/EX, EX/MEM and MEM/WB; CTRL_PIPELINE_PERF_EN adds a stall/flush bubble counter
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 7,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    Op_i,
  input  logic               valid_i,
  input  logic               Stall_i,
  input  logic               Flush_i,
  output logic               ex_valid_o,
  output logic [ALUOP_W-1:0] ex_ALUOp_o,
  output logic               ex_ALUSrc_o,
  output logic               ex_Branch_o,
  output logic               ex_Jump_o,
  output logic               ex_MemRead_o,
  output logic               mem_valid_o,
  output logic               mem_MemRead_o,
  output logic               mem_MemWrite_o,
  output logic               wb_valid_o,
  output logic               wb_RegWrite_o,
  output logic               wb_MemtoReg_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);
  ctrl_bundle_t dec, ex_q;
  logic dec_illegal, issue, load;
  logic ex_v, mem_v, mem_mr, mem_mw, mem_rw, mem_m2r, wb_v, wb_rw, wb_m2r, ill_q;
  ctrl_decode u_dec (.op(Op_i), .ctrl(dec), .illegal(dec_illegal));
  assign issue = valid_i & ~Stall_i & ~Flush_i;
  assign load  = issue & ~dec_illegal;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q <= '0;
      {ex_v, mem_v, mem_mr, mem_mw, mem_rw, mem_m2r, wb_v, wb_rw, wb_m2r, ill_q} <= '0;
    end else begin
      ex_v    <= load;
      ex_q    <= load ? dec : '0;
      mem_v   <= ex_v;
      mem_mr  <= ex_q.mem_read;
      mem_mw  <= ex_q.mem_write;
      mem_rw  <= ex_q.reg_write;
      mem_m2r <= ex_q.mem_to_reg;
      wb_v    <= mem_v;
      wb_rw   <= mem_rw;
      wb_m2r  <= mem_m2r;
      ill_q   <= ill_q | (issue & dec_illegal);
    end
  end
  assign ex_valid_o     = ex_v;
  assign ex_ALUOp_o     = ALUOP_W'(ex_q.alu_op);
  assign ex_ALUSrc_o    = ex_q.alu_src;
  assign ex_Branch_o    = ex_q.branch;
  assign ex_Jump_o      = ex_q.jump;
  assign ex_MemRead_o   = ex_q.mem_read;
  assign mem_valid_o    = mem_v;
  assign mem_MemRead_o  = mem_mr;
  assign mem_MemWrite_o = mem_mw;
  assign wb_valid_o     = wb_v;
  assign wb_RegWrite_o  = wb_rw;
  assign wb_MemtoReg_o  = wb_m2r;
  assign illegal_o      = ill_q;
`ifdef CTRL_PIPELINE_PERF_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else if ((Stall_i | Flush_i) && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
  end
  assign bubble_cnt_o = cnt_q;
`else
  assign bubble_cnt_o = '0;
`endif
endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: directed scoreboard bench for ctrl_pipeline (counter expectations follow CTRL_PIPELINE_PERF_EN)
module tb_ctrl_pipeline;
  logic clk = 1'b0, rst = 1'b0, valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [6:0] op = '0;
  logic ex_valid, ex_src, ex_br, ex_jp, ex_mr, mem_valid, mem_mr, mem_mw, wb_valid, wb_rw, wb_m2r, illegal;
  logic [2:0] ex_alu;
  logic [15:0] cnt;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [14:0] v;
    logic [15:0] c;
    int          step;
  } exp_t;
  exp_t q[$];
  logic [10:0] m_ex = '0;
  logic [4:0]  m_mem = '0;
  logic [2:0]  m_wb = '0;
  logic        m_ill = 1'b0;
  logic [15:0] m_cnt = '0;
  int          step_no = 0;

  always #5 clk = ~clk;

  ctrl_pipeline dut (
    .clk_i(clk), .rst_i(rst), .Op_i(op), .valid_i(valid), .Stall_i(stall), .Flush_i(flush),
    .ex_valid_o(ex_valid), .ex_ALUOp_o(ex_alu), .ex_ALUSrc_o(ex_src), .ex_Branch_o(ex_br),
    .ex_Jump_o(ex_jp), .ex_MemRead_o(ex_mr), .mem_valid_o(mem_valid), .mem_MemRead_o(mem_mr),
    .mem_MemWrite_o(mem_mw), .wb_valid_o(wb_valid), .wb_RegWrite_o(wb_rw), .wb_MemtoReg_o(wb_m2r),
    .illegal_o(illegal), .bubble_cnt_o(cnt)
  );

  // {legal, src, rw, m2r, mr, mw, br, jp, aluop}
  function automatic logic [10:0] tbl(input logic [6:0] o);
    case (o)
      7'b0110011: return 11'b1_0100000_000;
      7'b0010011: return 11'b1_1100000_001;
      7'b0000011: return 11'b1_1111000_010;
      7'b0100011: return 11'b1_1000100_010;
      7'b1100011: return 11'b1_0000010_011;
      7'b0110111: return 11'b1_1100000_100;
      7'b1101111: return 11'b1_0100001_101;
      default:    return 11'b0_0000000_000;
    endcase
  endfunction

  task automatic step(input logic [6:0] o, input logic v, input logic st, input logic fl, input logic rs);
    logic [10:0] t;
    exp_t e;
    op = o; valid = v; stall = st; flush = fl; rst = rs;
    t = tbl(o);
    if (rs) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_ill = 1'b0; m_cnt = '0;
    end else begin
      // m_ex = {v, alu[2:0], src, br, jp, mr, mw, rw, m2r}
      m_wb  = {m_mem[4], m_mem[1], m_mem[0]};
      m_mem = {m_ex[10], m_ex[3], m_ex[2], m_ex[1], m_ex[0]};
      m_ex  = (v && !st && !fl && t[10]) ? {1'b1, t[2:0], t[9], t[4], t[3], t[6], t[5], t[8], t[7]} : '0;
      if (v && !st && !fl && !t[10]) m_ill = 1'b1;
`ifdef CTRL_PIPELINE_PERF_EN
      if ((st || fl) && m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
`endif
    end
    e.v = {m_ex[10:4], m_ex[3], m_mem[4], m_mem[3], m_mem[2], m_wb, m_ill};
    e.c = m_cnt;
    e.step = step_no++;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(7'b0110011, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [14:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        act = {ex_valid, ex_alu, ex_src, ex_br, ex_jp, ex_mr, mem_valid, mem_mr, mem_mw, wb_valid, wb_rw, wb_m2r, illegal};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL ctrl step %0d: got %b expected %b", e.step, act, e.v);
        end
        checks++;
        if (cnt !== e.c) begin
          errors++;
          $display("FAIL bubble_cnt step %0d: got %0d expected %0d", e.step, cnt, e.c);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [6:0] ops [5];
    ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111};
    @(negedge clk);
    step(7'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(7'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(7'b0000011, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    for (int i = 0; i < 5; i++) step(ops[i], 1'b1, 1'b0, 1'b0, 1'b0);
    step(7'b0010011, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(7'b0000011, 1'b1, 1'b0, 1'b0, 1'b0);
    step(7'b0110011, 1'b1, 1'b1, 1'b0, 1'b0);
    step(7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(7'b0100011, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);
    step(7'b0100011, 1'b1, 1'b0, 1'b1, 1'b0);
    step(7'b0000011, 1'b0, 1'b0, 1'b0, 1'b0);
    step(7'b1111111, 1'b0, 1'b0, 1'b0, 1'b0);
    step(7'b1111111, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    step(7'b1111111, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(ops[i % 5], 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(7'b0000011, 1'b1, 1'b0, 1'b0, 1'b0);
    step(7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0);
    step(7'b0100011, 1'b1, 1'b1, 1'b0, 1'b0);
    step(7'b1101111, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
